l5_ram_ctrl: RTL and testbench
==============================

// Module: l5_ram_ctrl
// PURPOSE
//  Two-port access controller and arbiter for the 64x8 latch RAM.
//  Accepts read/write requests from two requesters and grants one at a time.
//  Sequences each transaction into the RAM's a/cs/oe/we/di pins and captures dout.
//  Sits between bus-side masters and the RAM; it is the only block that drives RAM control pins.
// PARAMETERS
//  AW  6  address width (64 words)
//  DW  8  data width
// PORTS
//  clk       in   1   system clock, rising edge
//  rst       in   1   asynchronous reset, active-high
//  req0      in   1   port 0 request; held until ack0
//  wr0       in   1   port 0 direction: 1=write, 0=read
//  addr0     in   AW  port 0 word address
//  wdata0    in   DW  port 0 write data
//  ack0      out  1   port 0 completion pulse, 1 cycle
//  req1/wr1/addr1/wdata1/ack1    port 1, same as port 0
//  rdata     out  DW  read data; valid in the ack cycle, held until next read completes
//  busy      out  1   high from SETUP through DONE
//  ram_a     out  AW  to RAM a
//  ram_cs    out  1   to RAM cs
//  ram_oe    out  1   to RAM oe
//  ram_we    out  1   to RAM we
//  ram_di    out  DW  to RAM di
//  ram_do    in   DW  from RAM dout
// BEHAVIOUR
//  Reset: state=IDLE; ack0/ack1/busy/ram_cs/ram_oe/ram_we=0; ram_a, ram_di, rdata=0; last_grant=1.
//  FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
//   IDLE: if any req, select winner. Register grant, wr, addr and wdata of the winner. Go to SETUP. Else stay.
//   SETUP (1 cyc): ram_cs=1; ram_a/ram_di driven from registers; oe=we=0.
//   ACCESS (1 cyc): ram_cs=1. ram_we=1 if write, else ram_oe=1. On a read, rdata<=ram_do at the closing edge.
//   DONE (1 cyc): ram_cs/oe/we=0; ack of the granted port=1. Update last_grant. Go to IDLE.
//  Latency: req sampled in IDLE at edge N -> ack high in cycle N+3. Throughput: 1 transaction per 4 cycles.
//  All RAM control outputs and acks are registered; no combinational path from req to RAM pins.
//  Request and payload are captured at grant. Later changes to addr/wdata/wr are ignored until DONE.
//  req dropped mid-transaction: the transaction still completes and ack still pulses.
//  Requester must drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
//  Simultaneous req0 & req1: resolved per CONFIGURATION. The loser is served next (see test plan).
//  Never more than one of ram_oe/ram_we high. Exactly one ack per granted transaction.
//  Async rst mid-transaction: immediate return to the reset values; the in-flight transaction is dropped with no ack.
// CONFIGURATION
//  L5_RR_ARB_EN defined:   round-robin arbitration. On a tie, the port != last_grant wins.
//  L5_RR_ARB_EN undefined: fixed priority, port 0 always wins a tie. last_grant is kept but unused.
//  Single-requester behaviour is identical in both builds.
// STRUCTURE
//  Shared package l5_ram_pkg:
//   - state encoding constants ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2, ST_DONE=2'd3
//   - L5_RAM_AW=6, L5_RAM_DW=8
//  Sub-module l5_rr_arbiter: 2-way arbiter.
//   - inputs req[1:0], last_grant, enable; output gnt[1:0], one-hot or zero
//   - macro selects RR vs fixed priority inside it
//  Top level holds the FSM, payload registers and RAM pin registers.
// TESTING
//  1. Reset: assert rst for 3 cycles mid-run -> all outputs 0 asynchronously; busy=0; no ack.
//  2. Port0 write then read: write addr0=6'h2A, wdata0=8'hC3 -> ack0 at N+3, ram_we high 1 cycle;
//     then read addr0=6'h2A -> rdata=8'hC3 with ack0.
//  3. Simultaneous req0/req1 writes (addr 5/9), both held until acked:
//     RR build -> port 1 first (last_grant=0 after the prior op), then port 0.
//     Fixed build -> port 0 first; ack spacing 4 cycles.
//  4. Stability: change addr0/wdata0 during SETUP -> RAM sees the captured values; mem[addr] holds the original data.
//  5. Boundary: write addr 6'h00=8'h01 and 6'h3F=8'hFE, read both back -> correct data.
//     ram_oe & ram_we never both 1 (assert).
//  6. Mid-transaction reset: assert rst in ACCESS of a write -> no ack; FSM IDLE; next request serviced normally.

Source files
------------

// File: rtl/l5_ram_pkg.sv
// Shared encodings and geometry for the 64x8 latch RAM access controller.
package l5_ram_pkg;

    localparam int L5_RAM_AW = 6;
    localparam int L5_RAM_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } l5_state_t;

endpackage

// File: rtl/l5_rr_arbiter.sv
// Two-way request arbiter. L5_RR_ARB_EN selects round-robin tie-breaking;
// otherwise port 0 always wins a tie.
module l5_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);

`ifndef L5_RR_ARB_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
`ifdef L5_RR_ARB_EN
                // Tie goes to the port that was not served last.
                gnt = last_grant ? 2'b01 : 2'b10;
`else
                gnt = 2'b01;
`endif
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/l5_ram_ctrl.sv
// Two-port arbitrated access controller for the 64x8 latch RAM.
// Build option: L5_RR_ARB_EN enables round-robin arbitration (default fixed priority).
module l5_ram_ctrl
    import l5_ram_pkg::*;
#(
    parameter int AW = L5_RAM_AW,
    parameter int DW = L5_RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] ram_a,
    output logic          ram_cs,
    output logic          ram_oe,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);

    l5_state_t  state;
    logic       last_grant;
    logic       sel;
    logic       wr_q;
    logic [1:0] gnt;

    l5_rr_arbiter u_arb (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .enable     (state == ST_IDLE),
        .gnt        (gnt)
    );

    // ram_a/ram_di double as the captured payload registers, so later
    // changes on the request side cannot reach the RAM pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            ram_cs     <= 1'b0;
            ram_oe     <= 1'b0;
            ram_we     <= 1'b0;
            ram_a      <= '0;
            ram_di     <= '0;
            rdata      <= '0;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (gnt != 2'b00) begin
                        sel    <= gnt[1];
                        wr_q   <= gnt[1] ? wr1 : wr0;
                        ram_a  <= gnt[1] ? addr1 : addr0;
                        ram_di <= gnt[1] ? wdata1 : wdata0;
                        ram_cs <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    ram_we <= wr_q;
                    ram_oe <= ~wr_q;
                    state  <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!wr_q) begin
                        rdata <= ram_do;
                    end
                    ram_cs <= 1'b0;
                    ram_oe <= 1'b0;
                    ram_we <= 1'b0;
                    ack0   <= ~sel;
                    ack1   <= sel;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    busy       <= 1'b0;
                    last_grant <= sel;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l5_ram_ctrl.sv
// Self-checking bench for l5_ram_ctrl with a behavioural RAM and reference memory.
module tb_l5_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, wr0, req1, wr1;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, busy;
    logic [7:0] rdata;
    logic [5:0] ram_a;
    logic       ram_cs, ram_oe, ram_we;
    logic [7:0] ram_di, ram_do;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [64];
    logic [7:0] ref_mem [64];
    bit         written [64];
    logic [7:0] last_rd;
    bit         last_serv;
    int         we_cnt = 0, oe_cnt = 0, ovl_cnt = 0;

    always #5 clk = ~clk;

    l5_ram_ctrl dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy),
        .ram_a(ram_a), .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    // Behavioural RAM: output enabled read, write on cs&we.
    assign ram_do = (ram_cs && ram_oe) ? mem[ram_a] : 8'h00;
    always @(posedge clk) if (ram_cs && ram_we) mem[ram_a] <= ram_di;

    always @(negedge clk) begin
        if (ram_we) we_cnt++;
        if (ram_oe) oe_cnt++;
        if (ram_oe && ram_we) ovl_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
        if (p) begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
    endtask

    // One transaction from an idle controller; called #1 after a rising edge.
    task automatic txn(input bit p, input bit w, input logic [5:0] a, input logic [7:0] d);
        int n = 0;
        bit got = 0;
        int we0 = we_cnt;
        int oe0 = oe_cnt;
        drive(p, 1'b1, w, a, d);
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if ((p ? ack1 : ack0) === 1'b1) got = 1;
        end
        chk("latency", n, 3);
        chk("other_ack", p ? ack0 : ack1, 0);
        chk("busy_in_done", busy, 1);
        if (!w) begin
            chk("rdata", rdata, ref_mem[a]);
            last_rd = ref_mem[a];
        end else begin
            chk("rdata_hold", rdata, last_rd);
            ref_mem[a] = d;
            written[a] = 1;
        end
        chk("we_cycles", we_cnt - we0, w ? 1 : 0);
        chk("oe_cycles", oe_cnt - oe0, w ? 0 : 1);
        drive(p, 1'b0, 1'b0, 6'h00, 8'h00);
        last_serv = p;
        @(posedge clk); #1;
        chk("ack_pulse", p ? ack1 : ack0, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int first, second, t1, t2, n, acks;
        bit exp_win, p, w;
        logic [5:0] a;
        logic [7:0] d, d0, d1;

        rst = 1'b1;
        req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        last_rd = 8'h00;
        last_serv = 1'b1;
        for (int i = 0; i < 64; i++) begin ref_mem[i] = 8'h00; written[i] = 0; end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cs", ram_cs, 0);
        chk("rst_oe", ram_oe, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_a", ram_a, 0);
        chk("rst_di", ram_di, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Port 0 write then read back
        txn(0, 1, 6'h2A, 8'hC3);
        txn(0, 0, 6'h2A, 8'h00);
        chk("rdata_2a", rdata, 8'hC3);

        // Simultaneous writes from both ports
`ifdef L5_RR_ARB_EN
        exp_win = ~last_serv;
`else
        exp_win = 1'b0;
`endif
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        drive(0, 1'b1, 1'b1, 6'd5, d0);
        drive(1, 1'b1, 1'b1, 6'd9, d1);
        first = -1; second = -1; t1 = 0; t2 = 0; n = 0; acks = 0;
        while (second < 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (ack0 === 1'b1) begin
                acks++;
                if (first < 0) begin first = 0; t1 = n; end else begin second = 0; t2 = n; end
                req0 = 1'b0;
            end
            if (ack1 === 1'b1) begin
                acks++;
                if (first < 0) begin first = 1; t1 = n; end else begin second = 1; t2 = n; end
                req1 = 1'b0;
            end
        end
        chk("tie_first", first, {31'd0, exp_win});
        chk("tie_second", second, {31'd0, ~exp_win});
        chk("tie_lat", t1, 3);
        chk("tie_spacing", t2 - t1, 4);
        chk("tie_ack_count", acks, 2);
        ref_mem[5] = d0; written[5] = 1;
        ref_mem[9] = d1; written[9] = 1;
        last_serv = ~exp_win;
        @(posedge clk); #1;
        chk("tie_busy_idle", busy, 0);
        txn(1, 0, 6'd5, 8'h00);
        txn(0, 0, 6'd9, 8'h00);

        // Payload changes after grant must not reach the RAM
        txn(1, 1, 6'h12, 8'h77);
        drive(0, 1'b1, 1'b1, 6'h11, 8'h5A);
        @(posedge clk); #1;
        chk("stab_busy", busy, 1);
        drive(0, 1'b1, 1'b0, 6'h12, 8'hA5);
        @(posedge clk); #1;
        chk("stab_a", ram_a, 6'h11);
        chk("stab_di", ram_di, 8'h5A);
        chk("stab_we", ram_we, 1);
        chk("stab_oe", ram_oe, 0);
        @(posedge clk); #1;
        chk("stab_ack", ack0, 1);
        drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
        ref_mem[6'h11] = 8'h5A; written[6'h11] = 1;
        last_serv = 1'b0;
        @(posedge clk); #1;
        txn(0, 0, 6'h12, 8'h00);
        txn(1, 0, 6'h11, 8'h00);

        // Address boundaries
        txn(0, 1, 6'h00, 8'h01);
        txn(1, 1, 6'h3F, 8'hFE);
        txn(1, 0, 6'h00, 8'h00);
        txn(0, 0, 6'h3F, 8'h00);

        // Random mix against the reference memory
        for (int i = 0; i < 12; i++) begin
            p = 1'($urandom);
            a = 6'($urandom);
            w = written[a] ? 1'($urandom) : 1'b1;
            d = 8'($urandom);
            txn(p, w, a, d);
        end

        // Reset during the ACCESS cycle of a write
        drive(0, 1'b1, 1'b1, 6'h20, 8'h99);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mr_we_before", ram_we, 1);
        rst = 1'b1;
        #1;
        chk("mr_cs", ram_cs, 0);
        chk("mr_we", ram_we, 0);
        chk("mr_busy", busy, 0);
        chk("mr_a", ram_a, 0);
        chk("mr_rdata", rdata, 0);
        drive(0, 1'b0, 1'b0, 6'h00, 8'h00);
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
        end
        chk("mr_no_ack", acks, 0);
        rst = 1'b0;
        written[6'h20] = 0;
        last_rd = 8'h00;
        last_serv = 1'b1;
        acks = 0;
        @(posedge clk); #1;
        if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
        chk("mr_no_late_ack", acks, 0);
        txn(1, 1, 6'h20, 8'h3C);
        txn(0, 0, 6'h20, 8'h00);

        chk("oe_we_exclusive", ovl_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
